nacc_exec_unit: RTL and testbench

Multi-cycle neuron-accumulate (NACC) execute unit in the EX stage. It consumes the ID/EX pipeline register outputs: weight vector, spike vector, neuron state, VL, destination tag and the NACC control bit. It computes the new membrane value serially, one lane per cycle. While it runs, it drives a stall back to the hazard logic so the ID/EX register and earlier stages hold. It returns a one-cycle result strobe toward EX/MEM and the NSR writeback path.

---
 rtl/nacc_pkg.sv | 30 +++
 rtl/nacc_exec_unit_if.sv | 34 +++
 rtl/nacc_mac.sv | 56 +++++
 rtl/nacc_exec_unit.sv | 133 +++++++++++++
 tb/tb_nacc_exec_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nacc_pkg.sv
// Shared types and constants for the neuron-accumulate (NACC) execute unit.
//   state_t      : control FSM states
//   LANES/WW/SW  : lane count, weight width, spike-count width
//   AW           : accumulator / membrane width
//   vl_to_lanes  : active lane count N = 4*(vl+1)
package nacc_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned WW    = 32;
  localparam int unsigned SW    = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned VLW   = 2;
  localparam int unsigned RDW   = 5;
  localparam int unsigned IDXW  = 4;
  localparam int unsigned NW    = 5;
  localparam int unsigned WVRW  = LANES * WW;
  localparam int unsigned SVRW  = LANES * SW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Active lane count for a VL encoding: 00->4, 01->8, 10->12, 11->16.
  function automatic logic [NW-1:0] vl_to_lanes(input logic [VLW-1:0] vl);
    return NW'({vl, 2'b00}) + NW'(4);
  endfunction

endpackage

// File: rtl/nacc_exec_unit_if.sv
// ID/EX-side bundle for the NACC execute unit.
//   master : pipeline side (drives operands/controls, observes results)
//   slave  : execute unit side
//   inputs to unit : start, flush, vl, wvr_data, svr_data, nsr_data, rd_in
//   outputs of unit: stall (combinational), busy, done, result, rd_out, sat_flag
interface nacc_exec_unit_if;
  import nacc_pkg::*;

  logic             start;
  logic             flush;
  logic [VLW-1:0]   vl;
  logic [WVRW-1:0]  wvr_data;
  logic [SVRW-1:0]  svr_data;
  logic [AW-1:0]    nsr_data;
  logic [RDW-1:0]   rd_in;

  logic             stall;
  logic             busy;
  logic             done;
  logic [AW-1:0]    result;
  logic [RDW-1:0]   rd_out;
  logic             sat_flag;

  modport master (
    output start, flush, vl, wvr_data, svr_data, nsr_data, rd_in,
    input  stall, busy, done, result, rd_out, sat_flag
  );

  modport slave (
    input  start, flush, vl, wvr_data, svr_data, nsr_data, rd_in,
    output stall, busy, done, result, rd_out, sat_flag
  );

endinterface

// File: rtl/nacc_mac.sv
// One-lane multiply-add: sum = reduce(acc + sext(w) * zext(s)).
// Build option NACC_SAT_EN: clamp the 41-bit sum to the signed 32-bit range
// and flag any clamp; otherwise wrap to the low 32 bits with o_sat = 0.
//   i_acc : current accumulator (signed)
//   i_w   : lane weight (signed)
//   i_s   : lane spike count (unsigned)
//   o_sum : reduced 32-bit sum
//   o_sat : clamp occurred this step
module nacc_mac
  import nacc_pkg::*;
(
  input  logic [AW-1:0] i_acc,
  input  logic [WW-1:0] i_w,
  input  logic [SW-1:0] i_s,
  output logic [AW-1:0] o_sum,
  output logic          o_sat
);

`ifdef NACC_SAT_EN
  localparam int unsigned XW = WW + SW + 1;

  logic signed [XW-1:0] w_w_ext;
  logic signed [XW-1:0] w_s_ext;
  logic signed [XW-1:0] w_prod;
  logic signed [XW-1:0] w_sum;
  logic                 w_pos_ovf;
  logic                 w_neg_ovf;

  assign w_w_ext = $signed({{(XW-WW){i_w[WW-1]}}, i_w});
  assign w_s_ext = $signed({{(XW-SW){1'b0}}, i_s});
  assign w_prod  = w_w_ext * w_s_ext;
  assign w_sum   = $signed({{(XW-AW){i_acc[AW-1]}}, i_acc}) + w_prod;

  // Out of range when the bits above the 32-bit sign bit disagree with it.
  assign w_pos_ovf = ~w_sum[XW-1] & (w_sum[XW-2:AW-1] != '0);
  assign w_neg_ovf =  w_sum[XW-1] & (w_sum[XW-2:AW-1] != '1);

  always_comb begin
    o_sum = w_sum[AW-1:0];
    o_sat = w_pos_ovf | w_neg_ovf;
    if (w_pos_ovf) begin
      o_sum = {1'b0, {(AW-1){1'b1}}};
    end else if (w_neg_ovf) begin
      o_sum = {1'b1, {(AW-1){1'b0}}};
    end
  end
`else
  logic [AW-1:0] w_prod_lo;

  // Low 32 bits of the product are identical for signed and unsigned multiply.
  assign w_prod_lo = AW'(i_w) * AW'(i_s);
  assign o_sum     = i_acc + w_prod_lo;
  assign o_sat     = 1'b0;
`endif

endmodule

// File: rtl/nacc_exec_unit.sv
// Multi-cycle NACC execute unit: accumulates one weight*spike lane per cycle
// into the neuron state, stalling the front of the pipe while it runs.
// Build option NACC_SAT_EN selects saturating accumulation (see nacc_mac).
//   clk, reset : clock, asynchronous active-low reset
//   bus        : nacc_exec_unit_if.slave
//     start/flush/vl/wvr_data/svr_data/nsr_data/rd_in from ID/EX
//     stall (combinational), busy, done, result, rd_out, sat_flag (registered)
module nacc_exec_unit
  import nacc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  nacc_exec_unit_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_next;

  logic [WVRW-1:0]   r_wvr;
  logic [SVRW-1:0]   r_svr;
  logic [RDW-1:0]    r_rd;
  logic [IDXW-1:0]   r_idx;
  logic [IDXW-1:0]   r_idx_last;
  logic [AW-1:0]     r_acc;
  logic              r_sat;

  logic              r_busy;
  logic              r_done;
  logic [AW-1:0]     r_result;
  logic [RDW-1:0]    r_rd_out;

  logic              w_accept;
  logic              w_last;
  logic [WW-1:0]     w_lane_w;
  logic [SW-1:0]     w_lane_s;
  logic [AW-1:0]     w_mac_sum;
  logic              w_mac_sat;

  assign w_accept = (r_state == IDLE) & bus.start & ~bus.flush;
  assign w_last   = (r_idx == r_idx_last);

  assign w_lane_w = r_wvr[{r_idx, 5'b00000} +: WW];
  assign w_lane_s = r_svr[{r_idx, 3'b000} +: SW];

  nacc_mac u_mac (
    .i_acc (r_acc),
    .i_w   (w_lane_w),
    .i_s   (w_lane_s),
    .o_sum (w_mac_sum),
    .o_sat (w_mac_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is ignored in DONE since the same instruction is still in ID/EX.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          w_state_next = IDLE;
        end else if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand latches, lane walk and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wvr      <= '0;
      r_svr      <= '0;
      r_rd       <= '0;
      r_idx      <= '0;
      r_idx_last <= '0;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_rd_out   <= '0;
    end else begin
      if (w_accept) begin
        r_wvr      <= bus.wvr_data;
        r_svr      <= bus.svr_data;
        r_rd       <= bus.rd_in;
        r_idx      <= '0;
        r_idx_last <= IDXW'(vl_to_lanes(bus.vl) - NW'(1));
        r_acc      <= bus.nsr_data;
        r_sat      <= 1'b0;
      end else if ((r_state == RUN) && !bus.flush) begin
        r_acc <= w_mac_sum;
        r_sat <= r_sat | w_mac_sat;
        r_idx <= r_idx + IDXW'(1);
        // Result and tag publish together with the done strobe.
        if (w_last) begin
          r_result <= w_mac_sum;
          r_rd_out <= r_rd;
        end
      end
      r_busy <= (w_state_next == RUN);
      r_done <= (w_state_next == DONE);
    end
  end

  // Hold request is live in the accepting cycle, so it cannot wait for a register.
  assign bus.stall    = reset & (w_accept | (r_state == RUN));
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.rd_out   = r_rd_out;
  assign bus.sat_flag = r_sat;

endmodule

// File: tb/tb_nacc_exec_unit.sv
// Self-checking bench for nacc_exec_unit: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (lane sum computed in 64-bit integer arithmetic).
module tb_nacc_exec_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  nacc_exec_unit_if bus();

  nacc_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cnt: cycles left in the current operation (0 = idle, 1 = done cycle).
  int          m_cnt     = 0;
  int          m_steps   = 0;
  logic [31:0] m_final   = '0;
  logic [31:0] m_result  = '0;
  logic [4:0]  m_rd_pend = '0;
  logic [4:0]  m_rd_out  = '0;
  bit          m_satpre [0:16];

  always @(posedge clk or negedge reset) begin : model
    longint acc;
    longint p;
    int     n;
    bit     sat;
    if (!reset) begin
      m_cnt    = 0;
      m_steps  = 0;
      m_result = '0;
      m_rd_out = '0;
      for (int i = 0; i <= 16; i++) m_satpre[i] = 1'b0;
    end else if (m_cnt == 0) begin
      if (bus.start && !bus.flush) begin
        n   = 4 * (int'(bus.vl) + 1);
        acc = longint'($signed(bus.nsr_data));
        sat = 1'b0;
        m_satpre[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
          p   = longint'($signed(bus.wvr_data[32*i +: 32])) * longint'(bus.svr_data[8*i +: 8]);
          acc = acc + p;
`ifdef NACC_SAT_EN
          if (acc > 64'sd2147483647) begin
            acc = 64'sd2147483647;
            sat = 1'b1;
          end else if (acc < -64'sd2147483648) begin
            acc = -64'sd2147483648;
            sat = 1'b1;
          end
`else
          acc = longint'($signed(acc[31:0]));
`endif
          m_satpre[i+1] = sat;
        end
        m_final   = acc[31:0];
        m_rd_pend = bus.rd_in;
        m_steps   = 0;
        m_cnt     = n + 1;
      end
    end else if (m_cnt == 1) begin
      m_cnt = 0;
    end else begin
      if (bus.flush) begin
        m_cnt = 0;
      end else begin
        m_steps++;
        m_cnt--;
        if (m_cnt == 1) begin
          m_result = m_final;
          m_rd_out = m_rd_pend;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit exp_stall;
    exp_stall = reset && ((m_cnt > 1) || (m_cnt == 0 && bus.start && !bus.flush));
    chk("stall",    32'(bus.stall),    32'(exp_stall));
    chk("busy",     32'(bus.busy),     32'(m_cnt > 1));
    chk("done",     32'(bus.done),     32'(m_cnt == 1));
    chk("result",   bus.result,        m_result);
    chk("rd_out",   32'(bus.rd_out),   32'(m_rd_out));
    chk("sat_flag", 32'(bus.sat_flag), 32'(m_satpre[m_steps]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation with start high (cycle 0), count stall cycles until done.
  task automatic run_op(input logic [1:0] vl, input logic [511:0] wv, input logic [127:0] sv,
                        input logic [31:0] nsr, input logic [4:0] rd, input bit hold,
                        output int stall_cnt, output int done_cyc);
    bus.vl       = vl;
    bus.wvr_data = wv;
    bus.svr_data = sv;
    bus.nsr_data = nsr;
    bus.rd_in    = rd;
    bus.start    = 1'b1;
    bus.flush    = 1'b0;
    stall_cnt    = 0;
    done_cyc     = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.stall) stall_cnt++;
      if (bus.done) begin
        done_cyc = k;
        break;
      end
    end
    tick();
    if (!hold) bus.start = 1'b0;
  endtask

  initial begin
    logic [511:0] wv;
    logic [127:0] sv;
    int sc, dc, dcount;

    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.vl       = '0;
    bus.wvr_data = '0;
    bus.svr_data = '0;
    bus.nsr_data = '0;
    bus.rd_in    = '0;

    #1 reset = 1'b0;
    #2;
    chk("rst_stall",  32'(bus.stall),    32'd0);
    chk("rst_busy",   32'(bus.busy),     32'd0);
    chk("rst_done",   32'(bus.done),     32'd0);
    chk("rst_result", bus.result,        32'd0);
    chk("rst_rd_out", 32'(bus.rd_out),   32'd0);
    chk("rst_sat",    32'(bus.sat_flag), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    tick();

    // Basic accumulate: 10 + 1+2+3+4.
    wv = '0; sv = '0;
    for (int i = 0; i < 4; i++) begin
      wv[32*i +: 32] = 32'(i + 1);
      sv[8*i +: 8]   = 8'd1;
    end
    run_op(2'b00, wv, sv, 32'd10, 5'd9, 1'b0, sc, dc);
    chk("basic_stall_cycles", 32'(sc), 32'd5);
    chk("basic_done_cycle",   32'(dc), 32'd5);
    @(negedge clk);
    chk("basic_result", bus.result,      32'd20);
    chk("basic_rd_out", 32'(bus.rd_out), 32'd9);

    // Flush mid-RUN: abort at cycle 2, prior result retained, no done.
    @(posedge clk); #1;
    wv = '1; sv = '1;
    bus.vl = 2'b11; bus.wvr_data = wv; bus.svr_data = sv;
    bus.nsr_data = 32'd77; bus.rd_in = 5'd3; bus.start = 1'b1;
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_stall",  32'(bus.stall), 32'd0);
    chk("flush_busy",   32'(bus.busy),  32'd0);
    chk("flush_result", bus.result,     32'd20);
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("flush_no_done", 32'(dcount), 32'd0);
    chk("flush_rd_kept", 32'(bus.rd_out), 32'd9);
    tick();

    // Full length: 16 lanes of -1 * 255.
    wv = '1; sv = '1;
    run_op(2'b11, wv, sv, 32'd0, 5'd17, 1'b0, sc, dc);
    chk("full_stall_cycles", 32'(sc), 32'd17);
    chk("full_done_cycle",   32'(dc), 32'd17);
    @(negedge clk);
    chk("full_result", bus.result,        32'hFFFF_F010);
    chk("full_sat",    32'(bus.sat_flag), 32'd0);
    tick();

    // Saturation / wrap: 0x7FFFFFFF * 2.
    wv = '0; sv = '0;
    wv[31:0] = 32'h7FFF_FFFF;
    sv[7:0]  = 8'd2;
    run_op(2'b00, wv, sv, 32'd0, 5'd4, 1'b0, sc, dc);
    chk("sat_done_cycle", 32'(dc), 32'd5);
    @(negedge clk);
`ifdef NACC_SAT_EN
    chk("sat_result", bus.result,        32'h7FFF_FFFF);
    chk("sat_flag",   32'(bus.sat_flag), 32'd1);
`else
    chk("sat_result", bus.result,        32'hFFFF_FFFE);
    chk("sat_flag",   32'(bus.sat_flag), 32'd0);
`endif
    tick();

    // Back-to-back: start held through DONE, new op at cycle N+2.
    wv = '0; sv = '0;
    for (int i = 0; i < 8; i++) begin
      wv[32*i +: 32] = 32'd2;
      sv[8*i +: 8]   = 8'd2;
    end
    run_op(2'b01, wv, sv, 32'd0, 5'd21, 1'b1, sc, dc);
    chk("b2b_a_done_cycle", 32'(dc), 32'd9);
    wv = '0; sv = '0;
    for (int i = 0; i < 4; i++) begin
      wv[32*i +: 32] = 32'd7;
      sv[8*i +: 8]   = 8'd3;
    end
    run_op(2'b00, wv, sv, 32'hFFFF_FFFF, 5'd22, 1'b0, sc, dc);
    chk("b2b_b_stall_cycles", 32'(sc), 32'd5);
    chk("b2b_b_done_cycle",   32'(dc), 32'd5);
    @(negedge clk);
    chk("b2b_b_result", bus.result,      32'd83);
    chk("b2b_b_rd_out", 32'(bus.rd_out), 32'd22);
    tick();

    // Async reset in RUN: outputs clear before any clock edge.
    wv = '1; sv = '1;
    bus.vl = 2'b11; bus.wvr_data = wv; bus.svr_data = sv;
    bus.nsr_data = 32'd5; bus.rd_in = 5'd30; bus.start = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("arst_stall",  32'(bus.stall),    32'd0);
    chk("arst_busy",   32'(bus.busy),     32'd0);
    chk("arst_done",   32'(bus.done),     32'd0);
    chk("arst_result", bus.result,        32'd0);
    chk("arst_rd_out", 32'(bus.rd_out),   32'd0);
    chk("arst_sat",    32'(bus.sat_flag), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    tick();
    wv = '0; sv = '0;
    for (int i = 0; i < 4; i++) begin
      wv[32*i +: 32] = 32'(i + 1);
      sv[8*i +: 8]   = 8'd1;
    end
    run_op(2'b00, wv, sv, 32'd10, 5'd11, 1'b0, sc, dc);
    chk("post_rst_done_cycle", 32'(dc), 32'd5);
    @(negedge clk);
    chk("post_rst_result", bus.result, 32'd20);
    tick();

    // Randomized traffic; operands change every cycle, model checks all outputs.
    for (int c = 0; c < 3000; c++) begin
      bus.start = ($urandom % 4) != 0;
      bus.flush = ($urandom % 24) == 0;
      bus.vl    = 2'($urandom);
      bus.rd_in = 5'($urandom);
      for (int l = 0; l < 16; l++) begin
        if ($urandom % 3 == 0) wv[32*l +: 32] = 32'($urandom);
        else                   wv[32*l +: 32] = 32'($urandom_range(0, 200)) - 32'd100;
        sv[8*l +: 8] = 8'($urandom);
      end
      bus.wvr_data = wv;
      bus.svr_data = sv;
      bus.nsr_data = ($urandom % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 1000));
      tick();
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    repeat (25) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
